ha_array_accumulator: RTL and testbench
=======================================

HA_ARRAY_ACCUMULATOR -- requirements
Module: ha_array_accumulator

Interface
REQ-001 SHALL have parameter OUT_W, default 16, product width in bits; only the value 16 is supported.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports ha_array_k_b, input, 7, carry-row bits of partial row k, for k = 0..3.
REQ-005 SHALL have ports ha_array_k_t, input, 9, sum-row bits of partial row k, for k = 0..3.
REQ-006 SHALL have port in_valid, input, 1, the eight ha_array inputs are valid.
REQ-007 SHALL have port in_ready, output, 1, block can accept a new operand set.
REQ-008 SHALL have port product, output, OUT_W, reduced product.
REQ-009 SHALL have port overflow, output, 1, true reduced sum exceeded 2^16-1.
REQ-010 SHALL have port out_valid, output, 1, product and overflow are valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the product.

Function
REQ-012 SHALL give row k bit t[j] the weight 2^(2k+j) and bit b[j] the weight 2^(2k+j+2).
REQ-013 SHALL define row value R_k = t_k + 4*b_k, a 10-bit quantity.
REQ-014 SHALL compute final value S = sum over k of R_k * 4^k, using an internal accumulator of at least 17 bits.
REQ-015 SHALL set product = S mod 2^16 and overflow = (S >= 2^16).
REQ-016 SHALL implement FSM states IDLE, ACC, DONE.
REQ-017 IDLE: in_ready = 1; on in_valid & in_ready, capture all eight inputs into internal registers, clear the accumulator and the row counter, and go to ACC.
REQ-018 ACC: in_ready = 0; each cycle add R_k * 4^k for row counter k, then increment k.
REQ-019 ACC: after row 3 is added, go to DONE.
REQ-020 SHALL add exactly one row per cycle in ACC, taken from the captured registers only; input changes during ACC or DONE SHALL have no effect.
REQ-021 DONE: out_valid = 1 and in_ready = 0; product and overflow SHALL be held stable while out_ready = 0.
REQ-022 DONE with out_ready = 1: go to IDLE next cycle, with out_valid = 0 in that cycle.
REQ-023 Latency: with out_ready tied high, a handshake in cycle N gives out_valid = 1 in cycle N+5 for exactly one cycle, and in_ready = 1 again in cycle N+6.
REQ-024 Throughput: one product per 6 cycles when out_ready is held high.
REQ-025 In IDLE, in_valid = 0 SHALL leave the FSM in IDLE.
REQ-026 out_valid and in_ready SHALL never be 1 in the same cycle.
REQ-027 product and overflow SHALL keep their last values outside DONE; they are meaningful only while out_valid = 1.

Reset
REQ-028 rst_n low SHALL immediately force, without waiting for a clock edge:
- state IDLE, in_ready = 1 (while rst_n is low, in_valid is ignored);
- out_valid = 0, product = 0, overflow = 0;
- accumulator = 0, row counter = 0.
REQ-029 Reset asserted during ACC or DONE SHALL abandon the operation, with no product emitted.
REQ-030 rst_n deassertion is synchronous to clk via the system reset synchronizer; the first handshake is accepted on the first edge after deassertion.

Verification
REQ-031 All inputs zero, in_valid pulse, out_ready = 1 -> product = 0, overflow = 0, out_valid exactly 5 cycles after the handshake.
REQ-032 Single bits, one per transaction:
- ha_array_1_t[0] = 1 -> product = 4;
- ha_array_3_b[6] = 1 -> product = 16384;
- ha_array_0_t[8] = 1 -> product = 256;
all with overflow = 0.
REQ-033 All t rows = 9'h1FF and all b rows = 7'h7F -> S = 86615, product = 21079 (16'h5257), overflow = 1.
REQ-034 Hold out_ready = 0 for 10 cycles in DONE, changing the inputs and pulsing in_valid -> product, out_valid = 1 and in_ready = 0 all stable; the captured value is unchanged after release.
REQ-035 Assert rst_n low during the second ACC cycle -> out_valid = 0 and in_ready = 1 immediately; after release, a new transaction with ha_array_0_t = 9'h003 -> product = 3.
REQ-036 Random back-to-back traffic with random out_ready stalls, checked against a software model of REQ-012 to REQ-015 -> all products match, with no loss or duplication.

Source files
------------

// File: rtl/ha_array_accumulator.sv
// Sequential reducer for four half-adder partial-product rows: one weighted row
// per cycle is folded into a wide accumulator, then held for a ready/valid consumer.
module ha_array_accumulator #(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       ha_array_0_b,
    input  logic [6:0]       ha_array_1_b,
    input  logic [6:0]       ha_array_2_b,
    input  logic [6:0]       ha_array_3_b,
    input  logic [8:0]       ha_array_0_t,
    input  logic [8:0]       ha_array_1_t,
    input  logic [8:0]       ha_array_2_t,
    input  logic [8:0]       ha_array_3_t,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] product,
    output logic             overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int ACC_W = OUT_W + 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       row_cnt;
    logic [ACC_W-1:0] acc;
    logic [8:0]       cap_t [4];
    logic [6:0]       cap_b [4];
    logic [OUT_W-1:0] product_q;
    logic             overflow_q;

    logic [9:0]       row_val;
    logic [2:0]       row_shift;
    logic [ACC_W-1:0] row_term;
    logic [ACC_W-1:0] acc_next;

    // Row k contributes (t + 4*b) scaled by 4^k, i.e. shifted left by 2k.
    always_comb begin
        row_val   = {1'b0, cap_t[row_cnt]} + {1'b0, cap_b[row_cnt], 2'b00};
        row_shift = {row_cnt, 1'b0};
        row_term  = {{(ACC_W-10){1'b0}}, row_val} << row_shift;
        acc_next  = acc + row_term;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            row_cnt    <= 2'd0;
            acc        <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cap_t[i] <= '0;
                cap_b[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        cap_t[0] <= ha_array_0_t;
                        cap_t[1] <= ha_array_1_t;
                        cap_t[2] <= ha_array_2_t;
                        cap_t[3] <= ha_array_3_t;
                        cap_b[0] <= ha_array_0_b;
                        cap_b[1] <= ha_array_1_b;
                        cap_b[2] <= ha_array_2_b;
                        cap_b[3] <= ha_array_3_b;
                        acc      <= '0;
                        row_cnt  <= 2'd0;
                        state    <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    acc     <= acc_next;
                    row_cnt <= row_cnt + 2'd1;
                    // Results live in their own registers so the next capture can clear acc.
                    if (row_cnt == 2'd3) begin
                        product_q  <= acc_next[OUT_W-1:0];
                        overflow_q <= |acc_next[ACC_W-1:OUT_W];
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign product   = product_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ha_array_accumulator.sv
// Self-checking bench for ha_array_accumulator: directed corner cases plus
// randomized back-to-back traffic against a bit-weight reference model.
module tb_ha_array_accumulator;

    logic        clk;
    logic        rst_n;
    logic [8:0]  tv [4];
    logic [6:0]  bv [4];
    logic        in_valid;
    logic        in_ready;
    logic [15:0] product;
    logic        overflow;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    ha_array_accumulator #(.OUT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ha_array_0_b (bv[0]),
        .ha_array_1_b (bv[1]),
        .ha_array_2_b (bv[2]),
        .ha_array_3_b (bv[3]),
        .ha_array_0_t (tv[0]),
        .ha_array_1_t (tv[1]),
        .ha_array_2_t (tv[2]),
        .ha_array_3_t (tv[3]),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .product      (product),
        .overflow     (overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: every set bit contributes its own power of two.
    function automatic int model_sum();
        int s = 0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 9; j++)
                if (tv[k][j]) s += 2 ** (2*k + j);
            for (int j = 0; j < 7; j++)
                if (bv[k][j]) s += 2 ** (2*k + j + 2);
        end
        return s;
    endfunction

    task automatic clear_inputs();
        for (int k = 0; k < 4; k++) begin
            tv[k] = '0;
            bv[k] = '0;
        end
    endtask

    task automatic randomize_inputs();
        for (int k = 0; k < 4; k++) begin
            tv[k] = 9'($urandom);
            bv[k] = 7'($urandom);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Handshake the current inputs and wait for out_valid; lat counts edges from the handshake edge.
    task automatic run_txn(output logic [15:0] p, output logic ov, output int lat);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            next_cycle();
            guard++;
        end
        in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            next_cycle();
            lat++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL txn_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
        end
        p  = product;
        ov = overflow;
    endtask

    task automatic test_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        clear_inputs();
        rst_n = 1'b0;
        #3;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'd0 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async: in_ready=%b out_valid=%b product=%h overflow=%b, required 1 0 0000 0",
                     in_ready, out_valid, product, overflow);
        end
        next_cycle();
        next_cycle();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hold: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_zero();
        logic [15:0] p;
        logic ov;
        int lat;
        clear_inputs();
        out_ready = 1'b1;
        run_txn(p, ov, lat);
        checks++;
        if (p !== 16'd0 || ov !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_product: got %h/%b, required 0000/0", p, ov);
        end
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("[TB] FAIL zero_latency: got %0d, required 5", lat);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_in_ready: got %b, required 0", in_ready);
        end
        next_cycle();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_return_idle: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_single_bits();
        logic [15:0] p;
        logic ov;
        int lat;
        logic [15:0] exp_p [3];
        exp_p[0] = 16'd4;
        exp_p[1] = 16'd16384;
        exp_p[2] = 16'd256;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            case (i)
                0: tv[1][0] = 1'b1;
                1: bv[3][6] = 1'b1;
                default: tv[0][8] = 1'b1;
            endcase
            run_txn(p, ov, lat);
            checks++;
            if (p !== exp_p[i] || ov !== 1'b0) begin
                errors++;
                $display("[TB] FAIL single_bit_%0d: got %0d/%b, required %0d/0", i, p, ov, exp_p[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_all_ones();
        logic [15:0] p;
        logic ov;
        int lat;
        for (int k = 0; k < 4; k++) begin
            tv[k] = 9'h1FF;
            bv[k] = 7'h7F;
        end
        out_ready = 1'b1;
        run_txn(p, ov, lat);
        checks++;
        if (p !== 16'h5257 || ov !== 1'b1) begin
            errors++;
            $display("[TB] FAIL all_ones: got %h/%b, required 5257/1", p, ov);
        end
        next_cycle();
    endtask

    task automatic test_stall();
        logic [15:0] p;
        logic ov;
        int lat;
        int s;
        randomize_inputs();
        s = model_sum();
        out_ready = 1'b0;
        run_txn(p, ov, lat);
        checks++;
        if (p !== 16'(s) || ov !== (s >= 65536)) begin
            errors++;
            $display("[TB] FAIL stall_value: got %h/%b, required %h/%b", p, ov, 16'(s), (s >= 65536));
        end
        for (int c = 0; c < 10; c++) begin
            randomize_inputs();
            in_valid = c[0];
            next_cycle();
            checks++;
            if (product !== 16'(s) || overflow !== (s >= 65536) || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold_%0d: product=%h ov=%b out_valid=%b in_ready=%b, required %h %b 1 0",
                         c, product, overflow, out_valid, in_ready, 16'(s), (s >= 65536));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        next_cycle();
        checks++;
        if (product !== 16'(s) || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_release: product=%h out_valid=%b in_ready=%b, required %h 0 1",
                     product, out_valid, in_ready, 16'(s));
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] p;
        logic ov;
        int lat;
        int seen = 0;
        randomize_inputs();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_async: out_valid=%b in_ready=%b product=%h, required 0 1 0000",
                     out_valid, in_ready, product);
        end
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_abandon: out_valid cycles=%0d, required 0", seen);
        end
        #3;
        rst_n = 1'b1;
        clear_inputs();
        tv[0] = 9'h003;
        run_txn(p, ov, lat);
        checks++;
        if (p !== 16'd3 || ov !== 1'b0 || lat !== 5) begin
            errors++;
            $display("[TB] FAIL reset_mid_after: got %0d/%b lat %0d, required 3/0 lat 5", p, ov, lat);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [16:0] expq [$];
        logic [16:0] e;
        int accepted = 0;
        int emitted  = 0;
        int bad      = 0;
        int guard;
        for (int c = 0; c < 400; c++) begin
            randomize_inputs();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                e = 17'(model_sum());
                expq.push_back(e);
                accepted++;
            end
            if (out_valid && in_ready) bad++;
            if (out_valid && out_ready) begin
                emitted++;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL b2b_extra: product=%h emitted with no outstanding operand set", product);
                end else begin
                    e = expq.pop_front();
                    if (product !== e[15:0] || overflow !== e[16]) begin
                        errors++;
                        $display("[TB] FAIL b2b_value_%0d: got %h/%b, required %h/%b",
                                 emitted, product, overflow, e[15:0], e[16]);
                    end
                end
            end
            next_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (expq.size() != 0 && guard < 50) begin
            if (out_valid) begin
                checks++;
                e = expq.pop_front();
                if (product !== e[15:0] || overflow !== e[16]) begin
                    errors++;
                    $display("[TB] FAIL b2b_drain: got %h/%b, required %h/%b", product, overflow, e[15:0], e[16]);
                end
            end
            next_cycle();
            guard++;
        end
        checks++;
        if (expq.size() != 0 || accepted < 10) begin
            errors++;
            $display("[TB] FAIL b2b_count: outstanding=%0d accepted=%0d, required 0 and >=10", expq.size(), accepted);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL b2b_exclusive: both valid/ready cycles=%0d, required 0", bad);
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        clear_inputs();
        #2;
        test_reset();
        test_zero();
        test_single_bits();
        test_all_ones();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
